// File: rtl/sync_pulse_multi.sv
// Multi-channel synchronizer with edge-to-pulse conversion, sticky pending/overflow flags and ack handshake.
// Optional saturating per-channel event counters are built only when SYNC_PULSE_CNT_EN is defined.
module sync_pulse_multi #(
    parameter int CH        = 4,
    parameter int STAGES    = 2,
    parameter int EDGE_MODE = 0,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       async_in,
    input  logic [CH-1:0]       ack,
    input  logic                cnt_clr,
    output logic [CH-1:0]       pulse_out,
    output logic [CH-1:0]       pending,
    output logic [CH-1:0]       overflow,
    output logic [CH*CNT_W-1:0] event_cnt
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [STAGES-1:0] chain;
        logic              prev_q;
        logic              sync_lvl;
        logic              hit;
        logic              pulse_q;
        logic              pend_q;
        logic              ovf_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                chain  <= '0;
                prev_q <= 1'b0;
            end else begin
                chain  <= {chain[STAGES-2:0], async_in[i]};
                prev_q <= chain[STAGES-1];
            end
        end

        assign sync_lvl = chain[STAGES-1];

        if (EDGE_MODE == 1) begin : g_fall
            assign hit = ~sync_lvl & prev_q;
        end else if (EDGE_MODE == 2) begin : g_both
            assign hit = sync_lvl ^ prev_q;
        end else begin : g_rise
            assign hit = sync_lvl & ~prev_q;
        end

        // A new edge outranks ack, so a same-cycle ack retires the old event without flagging overflow.
        always_ff @(posedge clk) begin
            if (rst) begin
                pulse_q <= 1'b0;
                pend_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                pulse_q <= hit;
                if (hit)
                    pend_q <= 1'b1;
                else if (ack[i])
                    pend_q <= 1'b0;
                if (hit && pend_q && !ack[i])
                    ovf_q <= 1'b1;
                else if (ack[i])
                    ovf_q <= 1'b0;
            end
        end

        assign pulse_out[i] = pulse_q;
        assign pending[i]   = pend_q;
        assign overflow[i]  = ovf_q;

`ifdef SYNC_PULSE_CNT_EN
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (rst)
                cnt_q <= '0;
            else if (cnt_clr)
                cnt_q <= CNT_W'(hit);
            else if (hit && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + 1'b1;
        end

        assign event_cnt[i*CNT_W +: CNT_W] = cnt_q;
`else
        assign event_cnt[i*CNT_W +: CNT_W] = '0;
`endif
    end

`ifndef SYNC_PULSE_CNT_EN
    logic cnt_clr_unused;
    assign cnt_clr_unused = cnt_clr;
`endif

endmodule

// File: tb/tb_sync_pulse_multi.sv
// Scoreboard bench for sync_pulse_multi: a rising-edge instance (2-bit counters) and a both-edge instance (4-bit counters)
// share stimulus; a sample-history model predicts every output each cycle.
module tb_sync_pulse_multi;

    localparam int CH  = 4;
    localparam int ST  = 2;
    localparam int CWA = 2;
    localparam int CWB = 4;
`ifdef SYNC_PULSE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [CH-1:0]       async_in;
    logic [CH-1:0]       ack;
    logic                cnt_clr;
    logic [CH-1:0]       pulse_a, pend_a, ovf_a;
    logic [CH-1:0]       pulse_b, pend_b, ovf_b;
    logic [CH*CWA-1:0]   cnt_a;
    logic [CH*CWB-1:0]   cnt_b;

    always #5 clk = ~clk;

    sync_pulse_multi #(.CH(CH), .STAGES(ST), .EDGE_MODE(0), .CNT_W(CWA)) dut_a (
        .clk(clk), .rst(rst), .async_in(async_in), .ack(ack), .cnt_clr(cnt_clr),
        .pulse_out(pulse_a), .pending(pend_a), .overflow(ovf_a), .event_cnt(cnt_a)
    );

    sync_pulse_multi #(.CH(CH), .STAGES(ST), .EDGE_MODE(2), .CNT_W(CWB)) dut_b (
        .clk(clk), .rst(rst), .async_in(async_in), .ack(ack), .cnt_clr(cnt_clr),
        .pulse_out(pulse_b), .pending(pend_b), .overflow(ovf_b), .event_cnt(cnt_b)
    );

    typedef struct packed {
        logic [CH-1:0]     pls_a, pnd_a, ovf_a;
        logic [CH*CWA-1:0] cnt_a;
        logic [CH-1:0]     pls_b, pnd_b, ovf_b;
        logic [CH*CWB-1:0] cnt_b;
    } exp_t;

    exp_t expq[$];
    int   nCompared   = 0;
    int   nMismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: h[i][k] is the input sample taken k+1 edges ago, so the synchronized level is h[ST-1] and its history h[ST].
    logic [ST:0]   h [CH];
    logic [CH-1:0] m_pls [2];
    logic [CH-1:0] m_pnd [2];
    logic [CH-1:0] m_ovf [2];
    int            m_cnt [2][CH];
    exp_t          e_new;

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < CH; i++) begin
                logic sy, pv, hit, old_pnd;
                int   cmax;
                sy      = h[i][ST-1];
                pv      = h[i][ST];
                hit     = (m == 0) ? (sy & ~pv) : (sy ^ pv);
                old_pnd = m_pnd[m][i];
                cmax    = (m == 0) ? 3 : 15;
                if (rst) begin
                    m_pls[m][i] = 1'b0;
                    m_pnd[m][i] = 1'b0;
                    m_ovf[m][i] = 1'b0;
                    m_cnt[m][i] = 0;
                end else begin
                    m_pls[m][i] = hit;
                    if (hit) m_pnd[m][i] = 1'b1;
                    else if (ack[i]) m_pnd[m][i] = 1'b0;
                    if (hit && old_pnd && !ack[i]) m_ovf[m][i] = 1'b1;
                    else if (ack[i]) m_ovf[m][i] = 1'b0;
                    if (!CNT_EN) m_cnt[m][i] = 0;
                    else if (cnt_clr) m_cnt[m][i] = hit ? 1 : 0;
                    else if (hit && m_cnt[m][i] < cmax) m_cnt[m][i] = m_cnt[m][i] + 1;
                end
            end
        end
        for (int i = 0; i < CH; i++)
            h[i] = rst ? '0 : {h[i][ST-1:0], async_in[i]};
        e_new.pls_a = m_pls[0]; e_new.pnd_a = m_pnd[0]; e_new.ovf_a = m_ovf[0];
        e_new.pls_b = m_pls[1]; e_new.pnd_b = m_pnd[1]; e_new.ovf_b = m_ovf[1];
        for (int i = 0; i < CH; i++) begin
            e_new.cnt_a[i*CWA +: CWA] = CWA'(m_cnt[0][i]);
            e_new.cnt_b[i*CWB +: CWB] = CWB'(m_cnt[1][i]);
        end
        expq.push_back(e_new);
    end

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            checkOutput("a_pulse",    32'(pulse_a), 32'(e.pls_a));
            checkOutput("a_pending",  32'(pend_a),  32'(e.pnd_a));
            checkOutput("a_overflow", 32'(ovf_a),   32'(e.ovf_a));
            checkOutput("a_count",    32'(cnt_a),   32'(e.cnt_a));
            checkOutput("b_pulse",    32'(pulse_b), 32'(e.pls_b));
            checkOutput("b_pending",  32'(pend_b),  32'(e.pnd_b));
            checkOutput("b_overflow", 32'(ovf_b),   32'(e.ovf_b));
            checkOutput("b_count",    32'(cnt_b),   32'(e.cnt_b));
        end
    end

    task automatic applyStimulus(input logic [CH-1:0] a, input logic [CH-1:0] k,
                                 input logic clr, input logic r, input int n);
        async_in = a;
        ack      = k;
        cnt_clr  = clr;
        rst      = r;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < CH; i++) h[i] = '0;
        for (int m = 0; m < 2; m++) begin
            m_pls[m] = '0; m_pnd[m] = '0; m_ovf[m] = '0;
            for (int i = 0; i < CH; i++) m_cnt[m][i] = 0;
        end

        // Reset, then first edge on ch0 and the ack/overflow handshake
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1, 2);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 2);
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 5);
        applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0, 1);
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 2);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 3);
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 4);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 3);
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 4);
        checkOutput("ovf_ch0_set", 32'(ovf_a[0]), 32'd1);
        applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0, 1);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 4);
        checkOutput("ovf_ch0_acked", 32'({pend_a[0], ovf_a[0]}), 32'd0);

        // ch1: ack lands on the very edge where the second event registers
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 4);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 4);
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 2);
        applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b0, 1);
        checkOutput("same_cycle_ack", 32'({pend_a[1], ovf_a[1]}), 32'b10);
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 3);

        // ch2/ch3 together: a 4-cycle high pulse
        applyStimulus(4'b1110, 4'b0000, 1'b0, 1'b0, 4);
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 5);

        // Saturation on ch0, then clear coincident with a fresh edge
        for (int r = 0; r < 5; r++) begin
            applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0, 3);
            applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 3);
        end
        checkOutput("sat_cnt_ch0", 32'(cnt_a[CWA-1:0]), CNT_EN ? 32'd3 : 32'd0);
        applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0, 2);
        applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b0, 1);
        applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0, 4);
        checkOutput("clr_edge_cnt_ch0", 32'(cnt_a[CWA-1:0]), CNT_EN ? 32'd1 : 32'd0);

        // Reset while a ch0 edge is still in the synchronizer
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 4);
        applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0, 1);
        applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b1, 2);
        checkOutput("midrst_flags", 32'({pulse_a, pend_a, ovf_a}), 32'd0);
        applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0, 6);
        checkOutput("post_rst_event", 32'(pend_a[0]), 32'd1);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
